// File: rtl/regfile_bypass_sb_pkg.sv
// Shared definitions for the RV32I register file and its hazard scoreboard.
package rv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned NREG_DEFAULT = 32;
    localparam int unsigned REG_IDX_W    = $clog2(NREG_DEFAULT);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_bypass_sb_scoreboard.sv
// Per-register pending scoreboard: tracks in-flight producers and flags RAW hazards to decode.
module rf_scoreboard
    import rv_pkg::*;
#(
    parameter int unsigned NREG     = NREG_DEFAULT,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned IDX_W   = $clog2(NREG),
    localparam int unsigned CNT_W   = $clog2(NREG) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rs1_addr,
    input  logic [IDX_W-1:0] rs2_addr,
    output logic             rs1_busy,
    output logic             rs2_busy,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic             iss_en,
    input  logic [IDX_W-1:0] iss_rd,
    output logic [CNT_W-1:0] pend_cnt
);

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;

    // Next pending vector: a new issue supersedes a retiring writeback to the same register.
    always_comb begin
        pend_nxt = pend;
        for (int r = 0; r < NREG; r++) begin
            if (iss_en && (iss_rd == IDX_W'(r))) begin
                pend_nxt[r] = 1'b1;
            end else if (wr_en && (wr_addr == IDX_W'(r))) begin
                pend_nxt[r] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            pend_nxt[0] = 1'b0;
        end
    end

    // Pending vector and its popcount, both cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= CNT_W'($countones(pend_nxt));
        end
    end

    // A producer retiring this cycle satisfies the read only when it can be forwarded.
    always_comb begin
        rs1_busy = pend[rs1_addr] && !((BYPASS != 0) && wr_en && (wr_addr == rs1_addr));
        rs2_busy = pend[rs2_addr] && !((BYPASS != 0) && wr_en && (wr_addr == rs2_addr));
    end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Integer register file with 2 combinational reads, 1 synchronous write, optional bypass and a hazard scoreboard.
module regfile_bypass_sb
    import rv_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEFAULT,
    parameter int unsigned NREG     = NREG_DEFAULT,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned IDX_W   = $clog2(NREG),
    localparam int unsigned CNT_W   = $clog2(NREG) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rs1_addr,
    input  logic [IDX_W-1:0] rs2_addr,
    output logic [XLEN-1:0]  rd_data1,
    output logic [XLEN-1:0]  rd_data2,
    output logic             rs1_busy,
    output logic             rs2_busy,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [XLEN-1:0]  wr_data,
    input  logic             iss_en,
    input  logic [IDX_W-1:0] iss_rd,
    output logic [CNT_W-1:0] pend_cnt
);

    localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(REG_ZERO);

    logic [XLEN-1:0] regs [NREG];
    logic            wr_ok;

    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == ZERO_IDX));

    // Architectural register array; x0 is never written when hardwired.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read port 1: hardwired zero, then same-cycle forward, then array.
    always_comb begin
        rd_data1 = regs[rs1_addr];
        if ((ZERO_REG != 0) && (rs1_addr == ZERO_IDX)) begin
            rd_data1 = '0;
        end else if ((BYPASS != 0) && wr_en && (wr_addr == rs1_addr)) begin
            rd_data1 = wr_data;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rd_data2 = regs[rs2_addr];
        if ((ZERO_REG != 0) && (rs2_addr == ZERO_IDX)) begin
            rd_data2 = '0;
        end else if ((BYPASS != 0) && wr_en && (wr_addr == rs2_addr)) begin
            rd_data2 = wr_data;
        end
    end

    rf_scoreboard #(
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .pend_cnt (pend_cnt)
    );

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: directed vector table, fill/reset sequence and random traffic vs a reference model.
module tb_regfile_bypass_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr, iss_rd;
    logic        wr_en, iss_en;
    logic [31:0] wr_data;

    logic [31:0] d1_b, d2_b, d1_n, d2_n;
    logic        b1_b, b2_b, b1_n, b2_n;
    logic [5:0]  cnt_b, cnt_n;

    int errors = 0;
    int checks = 0;

    // Reference model state: architectural values and in-flight producer flags.
    logic [31:0] m_regs [32];
    bit          m_pend [32];

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ir;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eb1;
        logic        eb2;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t vecs [15];

    always #5 clk = ~clk;

    regfile_bypass_sb #(.XLEN(32), .NREG(32), .ZERO_REG(1), .BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_data1(d1_b), .rd_data2(d2_b), .rs1_busy(b1_b), .rs2_busy(b2_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .pend_cnt(cnt_b)
    );

    regfile_bypass_sb #(.XLEN(32), .NREG(32), .ZERO_REG(1), .BYPASS(0)) dut_nob (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_data1(d1_n), .rd_data2(d2_n), .rs1_busy(b1_n), .rs2_busy(b2_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .pend_cnt(cnt_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        return m_pend[a] && !(byp && wr_en && wr_addr == a);
    endfunction

    function automatic logic [5:0] exp_cnt();
        int n = 0;
        foreach (m_pend[i]) n += int'(m_pend[i]);
        return 6'(n);
    endfunction

    task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ir, input logic [4:0] a1, input logic [4:0] a2);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        iss_en = ie; iss_rd = ir; rs1_addr = a1; rs2_addr = a2;
    endtask

    // Compare both DUTs (bypass and no-bypass) against the model for the current inputs.
    task automatic model_check();
        chk("byp_rd1",  d1_b,  exp_rd(rs1_addr, 1'b1));
        chk("byp_rd2",  d2_b,  exp_rd(rs2_addr, 1'b1));
        chk("byp_bsy1", 32'(b1_b), 32'(exp_busy(rs1_addr, 1'b1)));
        chk("byp_bsy2", 32'(b2_b), 32'(exp_busy(rs2_addr, 1'b1)));
        chk("byp_cnt",  32'(cnt_b), 32'(exp_cnt()));
        chk("nob_rd1",  d1_n,  exp_rd(rs1_addr, 1'b0));
        chk("nob_rd2",  d2_n,  exp_rd(rs2_addr, 1'b0));
        chk("nob_bsy1", 32'(b1_n), 32'(exp_busy(rs1_addr, 1'b0)));
        chk("nob_bsy2", 32'(b2_n), 32'(exp_busy(rs2_addr, 1'b0)));
        chk("nob_cnt",  32'(cnt_n), 32'(exp_cnt()));
    endtask

    // Advance one clock; the model takes the edge exactly as the spec's rules describe.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 32'h0;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
        end else begin
            if (wr_en && wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
            if (wr_en) m_pend[wr_addr] = 1'b0;
            if (iss_en && iss_rd != 5'd0) m_pend[iss_rd] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = 32'h0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;

        //         rst we wa  wd            ie ir r1 r2  e1            e2        eb1 eb2 ecnt
        vecs[0]  = '{1, 1, 5,  32'hDEADBEEF, 0, 0, 5, 0,  32'hDEADBEEF, 0,        0,  0,  0};
        vecs[1]  = '{0, 0, 0,  0,            0, 0, 5, 5,  0,            0,        0,  0,  0};
        vecs[2]  = '{0, 1, 7,  32'h12345678, 0, 0, 7, 7,  32'h12345678, 32'h12345678, 0, 0, 0};
        vecs[3]  = '{0, 0, 0,  0,            0, 0, 7, 0,  32'h12345678, 0,        0,  0,  0};
        vecs[4]  = '{0, 1, 0,  32'hFFFFFFFF, 1, 0, 0, 0,  0,            0,        0,  0,  0};
        vecs[5]  = '{0, 0, 0,  0,            0, 0, 0, 0,  0,            0,        0,  0,  0};
        vecs[6]  = '{0, 0, 0,  0,            1, 3, 0, 3,  0,            0,        0,  0,  0};
        vecs[7]  = '{0, 0, 0,  0,            0, 0, 0, 3,  0,            0,        0,  1,  1};
        vecs[8]  = '{0, 1, 3,  32'hA5,       0, 0, 0, 3,  0,            32'hA5,   0,  0,  1};
        vecs[9]  = '{0, 0, 0,  0,            0, 0, 0, 3,  0,            32'hA5,   0,  0,  0};
        vecs[10] = '{0, 0, 0,  0,            1, 9, 9, 0,  0,            0,        0,  0,  0};
        vecs[11] = '{0, 1, 9,  32'h55,       1, 9, 9, 0,  32'h55,       0,        0,  0,  1};
        vecs[12] = '{0, 0, 0,  0,            0, 0, 9, 0,  32'h55,       0,        1,  0,  1};
        vecs[13] = '{0, 1, 9,  32'h66,       0, 0, 9, 0,  32'h66,       0,        0,  0,  1};
        vecs[14] = '{0, 0, 0,  0,            0, 0, 9, 3,  32'h66,       32'hA5,   0,  0,  0};

        // Bring both copies out of an unknown power-up state.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // Directed table: reset priority, bypass, x0, hazard set/clear, issue-beats-writeback.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
                  vecs[i].ie, vecs[i].ir, vecs[i].r1, vecs[i].r2);
            #1;
            chk($sformatf("vec%0d_rd1", i),  d1_b, vecs[i].e1);
            chk($sformatf("vec%0d_rd2", i),  d2_b, vecs[i].e2);
            chk($sformatf("vec%0d_bsy1", i), 32'(b1_b), 32'(vecs[i].eb1));
            chk($sformatf("vec%0d_bsy2", i), 32'(b2_b), 32'(vecs[i].eb2));
            chk($sformatf("vec%0d_cnt", i),  32'(cnt_b), 32'(vecs[i].ecnt));
            model_check();
            tick();
        end

        // No-bypass copy: a same-cycle write shows the old value, then the new one.
        drive(0, 1, 11, 32'hCAFEF00D, 0, 0, 11, 11);
        #1;
        chk("nob_old_val", d1_n, 32'h0);
        chk("byp_new_val", d1_b, 32'hCAFEF00D);
        tick();
        drive(0, 0, 0, 0, 0, 0, 11, 11);
        #1;
        chk("nob_next_val", d1_n, 32'hCAFEF00D);
        tick();

        // Fill the scoreboard x1..x31 on consecutive cycles.
        for (int r = 1; r < 32; r++) begin
            drive(0, 0, 0, 0, 1, 5'(r), 5'(r), 0);
            #1;
            model_check();
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 31, 1);
        #1;
        chk("fill_cnt", 32'(cnt_b), 32'd31);
        chk("fill_bsy", 32'(b1_b & b2_b), 32'd1);

        // Reset while pending, with competing issue and writeback.
        drive(1, 1, 4, 32'h1111, 1, 6, 0, 0);
        tick();
        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
            #1;
            chk("rst_bsy1", 32'(b1_b), 32'd0);
            chk("rst_bsy2", 32'(b2_n), 32'd0);
        end
        chk("rst_cnt", 32'(cnt_b), 32'd0);
        model_check();
        tick();

        // Random traffic against the model, addresses biased low to force collisions.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] wa, ir, a1, a2;
            wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            ir = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            a1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            a2 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            drive(($urandom_range(0, 59) == 0), 1'($urandom), wa, $urandom,
                  1'($urandom), ir, a1, a2);
            #1;
            model_check();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
